// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a producer and the UART frame transmitter.
// The producer drives data_in/data_valid. The transmitter answers with data_ready.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame transmitter: start bit, MSB-first data, optional even parity, stop bit(s).
// The bit period is chosen from SelBaudRate and frozen for the whole frame at accept time.
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           SelBaudRate,
    uart_tx_serializer_if.slave  bus,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int DIV_4800   = CLK_FREQ / 4800;
    localparam int DIV_9600   = CLK_FREQ / 9600;
    localparam int DIV_57600  = CLK_FREQ / 57600;
    localparam int DIV_115200 = CLK_FREQ / 115200;
    localparam int CNT_W      = $clog2(DIV_4800 + 1);
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]  shift_r, shift_nxt_s;
    logic [CNT_W-1:0]       baud_r, baud_nxt_s;
    logic [CNT_W-1:0]       div_r, div_nxt_s, div_sel_s;
    logic [BIT_W-1:0]       bit_r, bit_nxt_s;
    logic                   parity_r, parity_nxt_s;
    logic                   tx_r, tx_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   accept_s;
    logic                   bit_end_s;

    assign bus.data_ready = (state_r == ST_IDLE) && !rst;
    assign accept_s       = bus.data_valid && bus.data_ready;
    assign bit_end_s      = (baud_r == {CNT_W{1'b0}});
    assign tx             = tx_r;
    assign tx_busy        = busy_r;
    assign tx_done        = done_r;

    // Bit-period lookup for the requested baud rate
    always_comb begin
        div_sel_s = CNT_W'(DIV_115200);
        case (SelBaudRate)
            2'b00:   div_sel_s = CNT_W'(DIV_4800);
            2'b01:   div_sel_s = CNT_W'(DIV_9600);
            2'b10:   div_sel_s = CNT_W'(DIV_57600);
            2'b11:   div_sel_s = CNT_W'(DIV_115200);
            default: div_sel_s = CNT_W'(DIV_115200);
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: every non-idle state lasts one full bit period
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_START;
                else          state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_nxt_s = ST_DATA;
                else           state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_r == LAST_DATA)) begin
                    state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) state_nxt_s = ST_STOP;
                else           state_nxt_s = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s && (bit_r == LAST_STOP)) state_nxt_s = ST_IDLE;
                else                                   state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath next values: shift register, baud/bit counters, latched divider
    always_comb begin
        shift_nxt_s  = shift_r;
        baud_nxt_s   = baud_r;
        bit_nxt_s    = bit_r;
        parity_nxt_s = parity_r;
        div_nxt_s    = div_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_nxt_s  = bus.data_in;
                    parity_nxt_s = even_parity(bus.data_in);
                    baud_nxt_s   = div_sel_s - CNT_W'(1);
                    bit_nxt_s    = {BIT_W{1'b0}};
                    div_nxt_s    = div_sel_s;
                end else begin
                    baud_nxt_s   = baud_r;
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (bit_end_s) begin
                    baud_nxt_s = div_r - CNT_W'(1);
                end else begin
                    baud_nxt_s = baud_r - CNT_W'(1);
                end
                if (bit_end_s && (state_r == ST_DATA)) begin
                    shift_nxt_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
                    bit_nxt_s   = (bit_r == LAST_DATA) ? {BIT_W{1'b0}} : bit_r + BIT_W'(1);
                end else if (bit_end_s && (state_r == ST_STOP)) begin
                    // Leaving STOP clears the counters so IDLE always looks like reset
                    if (bit_r == LAST_STOP) begin
                        bit_nxt_s  = {BIT_W{1'b0}};
                        baud_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        bit_nxt_s  = bit_r + BIT_W'(1);
                    end
                end else begin
                    bit_nxt_s = bit_r;
                end
            end
            default: begin
                baud_nxt_s = {CNT_W{1'b0}};
                bit_nxt_s  = {BIT_W{1'b0}};
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r  <= {DATA_WIDTH{1'b0}};
            baud_r   <= {CNT_W{1'b0}};
            bit_r    <= {BIT_W{1'b0}};
            parity_r <= 1'b0;
            div_r    <= {CNT_W{1'b0}};
        end else begin
            shift_r  <= shift_nxt_s;
            baud_r   <= baud_nxt_s;
            bit_r    <= bit_nxt_s;
            parity_r <= parity_nxt_s;
            div_r    <= div_nxt_s;
        end
    end

    // Output logic, decoded from the next state so tx changes with the state edge
    always_comb begin
        tx_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shift_nxt_s[DATA_WIDTH-1];
            ST_PARITY: tx_nxt_s = parity_nxt_s;
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_r == ST_STOP) && (state_nxt_s == ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at the default 10 MHz, 8E1 configuration.
// Each frame is checked bit by bit at the first and last clock of every bit period.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b11;
    logic       tx, tx_busy, tx_done;
    int         n_checks = 0;
    int         n_fail   = 0;

    uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .SelBaudRate (sel),
        .bus         (bus),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Presents a byte at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [7:0] d, input logic keep_valid);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        check("ready_before_accept", {31'd0, bus.data_ready}, 32'd1);
        @(negedge clk);
        if (!keep_valid) bus.data_valid = 1'b0;
    endtask

    // Called at the first START cycle; returns in the tx_done cycle
    task automatic check_frame(input string tag, input logic [7:0] d, input int div);
        logic [10:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[7-i];
        bits[9]  = ^d;
        bits[10] = 1'b1;
        check({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("%s_bit%0d_head", tag, k), {31'd0, tx}, {31'd0, bits[k]});
            repeat (div - 1) @(negedge clk);
            check($sformatf("%s_bit%0d_tail", tag, k), {31'd0, tx}, {31'd0, bits[k]});
            if (k == 10) check({tag, "_done_early"}, {31'd0, tx_done}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"},      {31'd0, tx_done},        32'd1);
        check({tag, "_done_tx"},   {31'd0, tx},             32'd1);
        check({tag, "_done_rdy"},  {31'd0, bus.data_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic done_seen;
        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;

        // Reset then idle
        repeat (10) @(negedge clk);
        check("rst_ready", {31'd0, bus.data_ready}, 32'd0);
        check("rst_tx",    {31'd0, tx},             32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx",    {31'd0, tx},             32'd1);
        check("idle_busy",  {31'd0, tx_busy},        32'd0);
        check("idle_done",  {31'd0, tx_done},        32'd0);
        check("idle_ready", {31'd0, bus.data_ready}, 32'd1);

        // 115200: 0xA5, parity 0, 946-clk frame
        sel = 2'b11;
        send(8'hA5, 1'b0);
        check_frame("a5", 8'hA5, 86);

        // 9600: 0x07, parity 1, 11451-clk frame
        @(negedge clk);
        sel = 2'b01;
        send(8'h07, 1'b0);
        check_frame("x07", 8'h07, 1041);

        // Back-to-back with data_valid held; data_in changes while busy
        @(negedge clk);
        sel = 2'b11;
        send(8'h3C, 1'b1);
        bus.data_in = 8'hC3;
        check_frame("b2b_3c", 8'h3C, 86);
        @(negedge clk);
        bus.data_valid = 1'b0;
        check_frame("b2b_c3", 8'hC3, 86);

        // Baud select changed mid-frame; next frame picks up 4800
        @(negedge clk);
        sel = 2'b11;
        send(8'h96, 1'b0);
        repeat (300) @(negedge clk);
        sel = 2'b00;
        repeat (86 * 11 - 300) @(negedge clk);
        check("sw_done", {31'd0, tx_done}, 32'd1);
        send(8'h81, 1'b0);
        check_frame("x81_slow", 8'h81, 2083);

        // Reset during DATA bit 3
        @(negedge clk);
        sel = 2'b11;
        send(8'h00, 1'b0);
        repeat (4 * 86 + 40) @(negedge clk);
        check("pre_rst_tx", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_tx",    {31'd0, tx},             32'd1);
        check("mid_rst_busy",  {31'd0, tx_busy},        32'd0);
        check("mid_rst_ready", {31'd0, bus.data_ready}, 32'd0);
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            done_seen = done_seen | tx_done;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            done_seen = done_seen | tx_done;
        end
        check("rst_no_done",    {31'd0, done_seen},      32'd0);
        check("post_rst_ready", {31'd0, bus.data_ready}, 32'd1);
        check("post_rst_tx",    {31'd0, tx},             32'd1);

        // 0x5A with a competing byte offered throughout the frame
        send(8'h5A, 1'b0);
        bus.data_in    = 8'hFF;
        bus.data_valid = 1'b1;
        check_frame("x5a", 8'h5A, 86);
        bus.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle_tx",   {31'd0, tx},      32'd1);
        check("end_idle_busy", {31'd0, tx_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Synthesizable UART frame transmitter: accepts one byte per valid/ready handshake and serializes it onto `tx`.
- Frame: start bit, DATA_WIDTH data bits MSB-first, optional even parity bit, STOP_BITS stop bits.
- Line format matches the rx unit's expected framing; the block is the remote-end driver for the rx path (replaces the behavioural driver task in link-level benches).
- Contains its own baud-tick divider selected by SelBaudRate.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- DATA_WIDTH, 8, data bits per frame.
- PARITY_EN, 1, 1 = append even-parity bit (XOR of data bits); 0 = no parity bit.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- SelBaudRate  in  2  00=4800, 01=9600, 10=57600, 11=115200 baud.
- data_in  in  DATA_WIDTH  byte to send; sampled on handshake.
- data_valid  in  1  data_in valid.
- data_ready  out  1  block can accept a byte (combinational).
- tx  out  1  serial line, idle high, registered.
- tx_busy  out  1  high from the cycle after accept until the frame ends.
- tx_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, tx_busy=0, tx_done=0, all counters 0; data_ready forced 0 while rst=1.
- Bit period DIV = CLK_FREQ/baud, integer-truncated. At defaults: 2083, 1041, 173, 86.
- DIV is selected from SelBaudRate and latched on accept. SelBaudRate changes mid-frame have no effect on the current frame.
- data_ready = (state==IDLE) && !rst. Handshake = data_valid && data_ready on a rising clk edge.
- On handshake:
  - latch data_in into the shift register;
  - compute parity = ^data_in;
  - load baud counter = DIV-1, bit counter = 0;
  - go to START.
- tx falls on the same edge, i.e. 1 clk after the handshake cycle.
- FSM states IDLE, START, DATA, PARITY, STOP. Each non-IDLE state holds tx for exactly DIV clocks: baud counter counts down; the state advances when it reaches 0 and reloads to DIV-1.
  - START: tx=0 -> DATA.
  - DATA: tx = shift_reg[DATA_WIDTH-1]; shift left at each bit end; bit counter increments. After DATA_WIDTH bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity -> STOP.
  - STOP: tx=1 for STOP_BITS*DIV clocks -> IDLE.
- Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*DIV clocks.
- tx_done=1 for exactly the one cycle in which the state is IDLE following STOP. data_ready is also 1 in that cycle.
- Back-to-back transfers: with data_valid held high, the next accept happens in the tx_done cycle, giving a 1-clk idle (tx=1) gap between frames.
- tx_busy=1 in every non-IDLE state; tx=1 whenever IDLE.
- data_in and data_valid are ignored while busy; data_valid without data_ready is not latched.
- Reset mid-frame: tx goes to 1 immediately, the frame is abandoned, no tx_done pulse. After rst deasserts, the block is IDLE with data_ready=1.
- Zero-valued DIV cannot occur at the default CLK_FREQ. It is an illegal configuration otherwise.

Test Plan:
- Reset then idle: rst=1 for 10 clk, release. Check tx=1, tx_busy=0, tx_done=0, data_ready=1.
- SelBaudRate=11, send 0xA5 (parity 0):
  - tx low at accept+1, held 86 clk;
  - data bits 1,0,1,0,0,1,0,1 each 86 clk;
  - parity 0, stop 1;
  - tx_done pulse exactly 946 clk after tx falls.
- SelBaudRate=01, send 0x07 (3 ones):
  - parity bit=1;
  - each bit 1041 clk;
  - frame 11451 clk.
- Back-to-back 0x3C then 0xC3 with data_valid held:
  - second accept in the tx_done cycle;
  - tx high exactly 1 clk between stop and next start;
  - both frames bit-correct.
- SelBaudRate switched 11->00 in the middle of a frame: current frame stays at 86 clk/bit; the next frame uses 2083.
- Async rst asserted during DATA bit 3:
  - tx=1 within the same cycle, no tx_done;
  - after release, 0x5A transmits correctly;
  - data_valid during busy never alters the in-flight frame.
